// File: rtl/logic_gate_pkg.sv
// rtl/logic_gate_pkg.sv - shared operator codes and helpers for the gate library
// Purpose: operator encoding, identity values and legality check for bitwise gate blocks.
// Ports: none (package).
package logic_gate_pkg;

    localparam int GATE_OP_W  = 3;
    // Widest lane the identity helper can describe; callers truncate to their width.
    localparam int GATE_MAX_W = 256;

    typedef enum logic [GATE_OP_W-1:0] {
        GATE_AND  = 3'd0,
        GATE_OR   = 3'd1,
        GATE_XOR  = 3'd2,
        GATE_NAND = 3'd3,
        GATE_NOR  = 3'd4,
        GATE_XNOR = 3'd5
    } gate_op_e;

    function automatic logic gate_is_legal(input logic [GATE_OP_W-1:0] op);
        return op <= GATE_XNOR;
    endfunction

    function automatic logic gate_is_inverting(input logic [GATE_OP_W-1:0] op);
        return (op == GATE_NAND) || (op == GATE_NOR) || (op == GATE_XNOR);
    endfunction

    // Value a masked lane takes so it does not disturb the reduction.
    function automatic logic [GATE_MAX_W-1:0] gate_identity(input logic [GATE_OP_W-1:0] op,
                                                             input int width);
        if (op == GATE_AND || op == GATE_NAND)
            return {GATE_MAX_W{1'b1}} >> (GATE_MAX_W - width);
        return '0;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - generic valid/ready register slice
// Purpose: one pipeline register with full backpressure.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_data upstream,
//        out_valid/out_ready/out_data downstream; payload width W.
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Slot frees up in the same cycle the downstream takes the current entry.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/logic_reduce_pipe.sv
// rtl/logic_reduce_pipe.sv - pipelined N-lane masked bitwise reduction
// Purpose: reduce N_IN lanes with AND/OR/XOR (optionally inverted) through two register stages.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_mask/in_op input stream;
//        out_valid/out_ready/out_data/out_err/out_zero result stream.
module logic_reduce_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_mask,
    input  logic [GATE_OP_W-1:0]  in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_err,
    output logic                  out_zero
);

    localparam int S1_W = WIDTH + 2;
    localparam int S2_W = WIDTH + 2;

    logic [WIDTH-1:0] ident;
    logic [WIDTH-1:0] lane;
    logic [WIDTH-1:0] acc;
    logic             inv;
    logic             err;

    always_comb begin
        ident = WIDTH'(gate_identity(in_op, WIDTH));
        acc   = ident;
        lane  = '0;
        inv   = gate_is_inverting(in_op);
        err   = !gate_is_legal(in_op);
        for (int i = 0; i < N_IN; i++) begin
            lane = in_mask[i] ? in_data[i*WIDTH +: WIDTH] : ident;
            case (in_op)
                GATE_AND,  GATE_NAND: acc = acc & lane;
                GATE_OR,   GATE_NOR:  acc = acc | lane;
                GATE_XOR,  GATE_XNOR: acc = acc ^ lane;
                default:              acc = '0;
            endcase
        end
        // Illegal ops travel as a zero result with no inversion so stage 2 emits 0.
        if (err) begin
            acc = '0;
            inv = 1'b0;
        end
    end

    logic             s1_valid;
    logic [S1_W-1:0]  s1_data;
    logic             s2_ready;
    logic [WIDTH-1:0] s1_red;
    logic             s1_inv;
    logic             s1_err;
    logic [WIDTH-1:0] s2_result;
    logic [S2_W-1:0]  s2_out;

    pipe_stage #(.W(S1_W)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({acc, inv, err}),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    assign {s1_red, s1_inv, s1_err} = s1_data;
    assign s2_result = s1_inv ? ~s1_red : s1_red;

    pipe_stage #(.W(S2_W)) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   ({s2_result, (s2_result == '0), s1_err}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

    assign {out_data, out_zero, out_err} = s2_out;

endmodule
